// File: rtl/temporal_pkg.sv
// Shared types and helpers for the race-logic temporal encoder/decoder pair.
package temporal_pkg;

  typedef enum logic {
    ENC_IDLE,
    ENC_RUN
  } enc_state_e;

  // A lane with arrival time t is active at phase p when t is a real time
  // (below the gamma length g) and p lies in [t, t+pw). The arguments are
  // 32 bits wide, so t+pw cannot wrap for any legal time field.
  function automatic logic in_window(input int unsigned t,
                                     input int unsigned p,
                                     input int unsigned g,
                                     input int unsigned pw);
    return (t < g) && (t <= p) && (p < t + pw);
  endfunction

endpackage

// File: rtl/temporal_lane.sv
// One temporal output lane: registers the spike for the upcoming phase so the
// output is a clean flop driven by the encoder's next state.
module temporal_lane
  import temporal_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned TW                = $clog2(GAMMA_CYCLE_WIDTH) + 1,
  parameter int unsigned PHASE_W           = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic               aclk,
  input  logic               grst,
  input  logic               run_next,
  input  logic [PHASE_W-1:0] phase_next,
  input  logic [TW-1:0]      t,
  output logic               spike
);

  // Spike is high for the phases inside this lane's window while running.
  always_ff @(posedge aclk) begin
    if (grst) begin
      spike <= 1'b0;
    end else begin
      spike <= run_next &&
               in_window(32'(t), 32'(phase_next), GAMMA_CYCLE_WIDTH, PULSE_WIDTH);
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal transmitter: accepts time vectors over valid/ready and
// replays them as spikes inside gamma cycles, with a set strobe at phase 0.
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int NUM_LANES         = 4,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH) + 1
) (
  input  logic                                 aclk,
  input  logic                                 grst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [NUM_LANES*TW-1:0]              in_time,
  output logic                                 set,
  output logic [NUM_LANES-1:0]                 spike,
  output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] phase,
  output logic                                 busy
);

  localparam int PHASE_W = $clog2(GAMMA_CYCLE_WIDTH);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(GAMMA_CYCLE_WIDTH - 1);

  enc_state_e                state_q, state_n;
  logic [PHASE_W-1:0]        phase_q, phase_n;
  logic [NUM_LANES*TW-1:0]   act_q, act_n;
  logic [NUM_LANES*TW-1:0]   hold_q, hold_n;
  logic                      hold_v_q, hold_v_n;
  logic                      set_q;
  logic                      handshake;
  logic                      run_next;

  assign in_ready  = ~hold_v_q & ~grst;
  assign handshake = in_valid & in_ready;
  assign run_next  = (state_n == ENC_RUN);

  assign set   = set_q;
  assign phase = phase_q;
  assign busy  = (state_q == ENC_RUN);

  // State, phase counter, active/holding registers and the set strobe.
  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q  <= ENC_IDLE;
      phase_q  <= '0;
      act_q    <= '0;
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      act_q    <= act_n;
      hold_q   <= hold_n;
      hold_v_q <= hold_v_n;
      set_q    <= run_next && (phase_n == '0);
    end
  end

  // Next-state logic: start from idle, park a vector in the holding slot
  // mid-cycle, and at the last phase either promote the held vector, bypass
  // a fresh one straight in, or fall back to idle.
  always_comb begin
    state_n  = state_q;
    phase_n  = phase_q;
    act_n    = act_q;
    hold_n   = hold_q;
    hold_v_n = hold_v_q;
    case (state_q)
      ENC_IDLE: begin
        phase_n = '0;
        if (handshake) begin
          act_n   = in_time;
          state_n = ENC_RUN;
        end
      end
      ENC_RUN: begin
        if (phase_q == LAST_PHASE) begin
          phase_n = '0;
          if (hold_v_q) begin
            act_n    = hold_q;
            hold_v_n = 1'b0;
          end else if (handshake) begin
            act_n = in_time;
          end else begin
            state_n = ENC_IDLE;
          end
        end else begin
          phase_n = phase_q + PHASE_W'(1);
          if (handshake) begin
            hold_n   = in_time;
            hold_v_n = 1'b1;
          end
        end
      end
      default: begin
        state_n = ENC_IDLE;
        phase_n = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    temporal_lane #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
      .PULSE_WIDTH      (PULSE_WIDTH),
      .TW               (TW),
      .PHASE_W          (PHASE_W)
    ) u_lane (
      .aclk      (aclk),
      .grst      (grst),
      .run_next  (run_next),
      .phase_next(phase_n),
      .t         (act_n[i*TW +: TW]),
      .spike     (spike[i])
    );
  end

endmodule

// File: tb/tb_temporal_encoder.sv
// Directed self-checking bench for temporal_encoder (G=16, P=8, N=4) plus a
// second instance with P=G=16.
module tb_temporal_encoder;

  logic        aclk = 1'b0;
  logic        grst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_time;
  logic        set;
  logic [3:0]  spike;
  logic [3:0]  phase;
  logic        busy;

  logic        v2;
  logic        rdy2;
  logic [19:0] t2;
  logic        set2;
  logic [3:0]  spike2;
  logic [3:0]  phase2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .NUM_LANES(4)) dut (
    .aclk(aclk), .grst(grst), .in_valid(in_valid), .in_ready(in_ready),
    .in_time(in_time), .set(set), .spike(spike), .phase(phase), .busy(busy)
  );

  temporal_encoder #(.GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(16), .NUM_LANES(4)) dut_full (
    .aclk(aclk), .grst(grst), .in_valid(v2), .in_ready(rdy2),
    .in_time(t2), .set(set2), .spike(spike2), .phase(phase2), .busy(busy2)
  );

  function automatic logic [19:0] vec4(input logic [4:0] t3, input logic [4:0] t2v,
                                       input logic [4:0] t1, input logic [4:0] t0);
    return {t3, t2v, t1, t0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge aclk);
    #1;
  endtask

  // Present a vector until it is accepted; returns one step after the accepting edge.
  task automatic applyStimulus(input logic [19:0] vec, input bit drop);
    bit ok;
    bit rdy;
    ok = 1'b0;
    in_valid = 1'b1;
    in_time = vec;
    for (int i = 0; i < 40 && !ok; i++) begin
      rdy = in_ready;
      stepCycle();
      ok = rdy;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
    if (drop) in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 60 && busy; i++) stepCycle();
    checkOutput("idle_reached", busy, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  cyc;
    bit  seen;
    bit  p0, p1, coin, ra, rb, ne;
    logic [4:0] bt;

    grst = 1'b1;
    in_valid = 1'b0;
    in_time = '0;
    v2 = 1'b0;
    t2 = '0;
    stepCycle();
    stepCycle();
    checkOutput("rst_phase", phase, 0);
    checkOutput("rst_set", set, 0);
    checkOutput("rst_spike", spike, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready_in_reset", in_ready, 0);
    grst = 1'b0;
    #1;
    checkOutput("rst_ready_after", in_ready, 1);

    // Single vector {0,3,15,16}; in_time is scrambled after acceptance.
    applyStimulus(vec4(5'd16, 5'd15, 5'd3, 5'd0), 1);
    in_time = vec4(5'd0, 5'd0, 5'd0, 5'd0);
    for (int c = 1; c <= 17; c++) begin
      checkOutput("single_lane0", spike[0], (c >= 1 && c <= 8));
      checkOutput("single_lane1", spike[1], (c >= 4 && c <= 11));
      checkOutput("single_lane2", spike[2], (c == 16));
      checkOutput("single_lane3", spike[3], 0);
      checkOutput("single_set", set, (c == 1));
      checkOutput("single_busy", busy, (c <= 16));
      checkOutput("single_phase", phase, (c <= 16) ? c - 1 : 0);
      if (c < 17) stepCycle();
    end

    // Back-to-back: A accepted from idle, B accepted one cycle later into hold.
    applyStimulus(vec4(5'd16, 5'd16, 5'd16, 5'd0), 0);
    checkOutput("b2b_first_set", set, 1);
    applyStimulus(vec4(5'd16, 5'd16, 5'd16, 5'd2), 1);
    cyc = 2;
    while (!set && cyc < 40) begin
      checkOutput("b2b_ready_low", in_ready, 0);
      checkOutput("b2b_busy", busy, 1);
      stepCycle();
      cyc++;
    end
    checkOutput("b2b_set_period", cyc - 1, 16);
    checkOutput("b2b_phase0", phase, 0);
    checkOutput("b2b_ready_back", in_ready, 1);
    checkOutput("b2b_busy_after", busy, 1);
    checkOutput("b2b_lane0_early", spike[0], 0);
    stepCycle();
    stepCycle();
    checkOutput("b2b_lane0_t2", spike[0], 1);
    waitIdle();

    // Bypass: new vector presented only during the last phase.
    applyStimulus(vec4(5'd16, 5'd16, 5'd16, 5'd0), 1);
    for (int i = 0; i < 40 && phase != 4'd15; i++) stepCycle();
    checkOutput("byp_at_last", phase, 15);
    in_valid = 1'b1;
    in_time = vec4(5'd16, 5'd16, 5'd16, 5'd1);
    stepCycle();
    in_valid = 1'b0;
    checkOutput("byp_phase0", phase, 0);
    checkOutput("byp_set", set, 1);
    checkOutput("byp_busy", busy, 1);
    checkOutput("byp_lane0_p0", spike[0], 0);
    stepCycle();
    checkOutput("byp_lane0_p1", spike[0], 1);
    checkOutput("byp_phase1", phase, 1);
    waitIdle();

    // Reset mid-run with a held vector that must not be replayed.
    applyStimulus(vec4(5'd16, 5'd16, 5'd16, 5'd0), 1);
    applyStimulus(vec4(5'd16, 5'd16, 5'd0, 5'd0), 1);
    for (int i = 0; i < 40 && phase != 4'd5; i++) stepCycle();
    checkOutput("mrst_phase5", phase, 5);
    checkOutput("mrst_hold_full", in_ready, 0);
    checkOutput("mrst_lane0_live", spike[0], 1);
    grst = 1'b1;
    stepCycle();
    checkOutput("mrst_spike", spike, 0);
    checkOutput("mrst_set", set, 0);
    checkOutput("mrst_busy", busy, 0);
    checkOutput("mrst_phase", phase, 0);
    grst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      if (busy || set || (spike != 4'd0)) seen = 1'b1;
    end
    checkOutput("mrst_no_replay", seen, 0);
    checkOutput("mrst_ready", in_ready, 1);

    // Loopback through a not_equal primitive: a=lane0, b=lane1.
    for (int r = 0; r < 2; r++) begin
      bt = (r == 0) ? 5'd3 : 5'd7;
      applyStimulus(vec4(5'd16, 5'd16, bt, 5'd3), 1);
      p0 = 1'b0;
      p1 = 1'b0;
      coin = 1'b0;
      for (int c = 1; c <= 17; c++) begin
        ra = spike[0] & ~p0;
        rb = spike[1] & ~p1;
        if (ra) coin = rb;
        ne = spike[0] & ~coin;
        if (r == 0) checkOutput("ne_equal", ne, 0);
        else        checkOutput("ne_differ", ne, (c >= 4 && c <= 11));
        p0 = spike[0];
        p1 = spike[1];
        if (c < 17) stepCycle();
      end
      waitIdle();
    end

    // Full-width pulse: P=G=16, t=0 covers the entire gamma cycle.
    v2 = 1'b1;
    t2 = vec4(5'd16, 5'd16, 5'd16, 5'd0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      seen = rdy2;
      stepCycle();
    end
    v2 = 1'b0;
    checkOutput("full_accept", seen, 1);
    checkOutput("full_set", set2, 1);
    for (int c = 1; c <= 16; c++) begin
      checkOutput("full_lane0_high", spike2[0], 1);
      stepCycle();
    end
    checkOutput("full_lane0_low", spike2[0], 0);
    checkOutput("full_busy_low", busy2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Binary-to-temporal transmitter for the race-logic datapath. It accepts a vector of binary arrival times over a valid/ready handshake and replays them as spikes inside a gamma cycle. It also generates the per-gamma-cycle `set` strobe that downstream temporal primitives (not_equal, min/max, inhibit) use to arm their latches. It is the producing end of the temporal interface those primitives consume.

## Interface
- GAMMA_CYCLE_WIDTH, 16: aclk cycles per gamma cycle (G); ≥2.
- PULSE_WIDTH, 8: spike length in aclk cycles (P); 1..G.
- NUM_LANES, 4: parallel temporal outputs (N).
- TW, $clog2(GAMMA_CYCLE_WIDTH)+1: width of each binary time field.
- aclk  in  1  sole clock; all state updates on posedge.
- grst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer has a time vector.
- in_ready  out  1  encoder can accept a vector this cycle.
- in_time  in  N×TW  per-lane arrival time; value ≥ G means "never" (∞, no spike).
- set  out  1  high for exactly phase 0 of every running gamma cycle.
- spike  out  N  per-lane temporal signal.
- phase  out  $clog2(G)  current gamma phase; 0 when idle.
- busy  out  1  a gamma cycle is in progress.

## Operation
- FSM states: IDLE, RUN. Holding register: one entry (`hold_q`, `hold_v`). Active register: `act_q`.
- in_ready = ~hold_v; 0 while grst is high.
- Handshake at edge E: in_valid & in_ready.
- IDLE + handshake: vector goes directly to `act_q`. Next state is RUN with phase=0.
- RUN + handshake, phase < G-1: vector goes to `hold_q`, and hold_v ← 1.
- RUN, phase = G-1 (end of gamma cycle):
  - If hold_v: act ← hold, hold_v ← 0, phase ← 0, stay RUN.
  - Else, if a handshake occurs at this edge: bypass into `act_q`, phase ← 0, stay RUN.
  - Else: go to IDLE.
  - No dead cycle between back-to-back gamma cycles.
- Lane i spike is high during phase p iff RUN and t_i < G and t_i ≤ p < t_i + P.
  - Compare in TW+1 bits so t_i + P never wraps.
  - A spike is truncated at phase G-1. It never carries into the next gamma cycle.
  - A spike starting at p=0 coincides with `set`.
- t_i ≥ G (including all-ones): lane stays low for the whole gamma cycle.
- busy = (state == RUN).

## Timing
- All outputs are registered and are functions of the registered (state, phase, act_q).
- Latency: a handshake at edge E in IDLE puts set=1, phase=0 in the cycle after E. Lane i rises t_i cycles after that.
- set pulse width is exactly 1 aclk cycle per gamma cycle.
- Reset values (cycle after a grst edge): state=IDLE, phase=0, set=0, spike=0, busy=0, hold_v=0; in_ready=1 once grst is low.
- Reset mid-gamma-cycle: all spikes and set drop on the next cycle. The held vector is discarded, with no partial replay.
- in_valid held high continuously produces gamma cycles of exactly G cycles each, with set period G.
- in_time is sampled only at the handshake edge. Later changes have no effect.

## Structure
- `temporal_pkg`: FSM enum (`ENC_IDLE`, `ENC_RUN`) and a function `in_window(t, p, G, P)` returning spike-active. The same package also serves the future temporal_decoder.
- Sub-module `temporal_lane`: one lane's registered window compare (inputs phase_next, t, run_next; output spike). It is instantiated N times via generate.
- Top level holds the FSM, phase counter, holding/active registers and the handshake. Expected RTL size is ~150–250 lines total.

## Test plan
(G=16, P=8, N=4 unless noted)
- Single vector {0,3,15,16} from IDLE:
  - set at cycle 1.
  - lane0 high cycles 1–8; lane1 high 4–11; lane2 high only at cycle 16 (truncated); lane3 never high.
  - busy falls after cycle 16.
- Back-to-back: in_valid held high with vectors A then B:
  - Second set exactly 16 cycles after the first.
  - in_ready low from B's acceptance until the A→B transfer.
  - No idle cycle between the two gamma cycles.
- Bypass: vector presented only on the edge ending phase 15 with hold empty → next gamma cycle starts immediately with phase 0.
- Reset mid-run: grst asserted at phase 5 with hold_v=1 → next cycle spike=0, set=0, busy=0. After release, no replay of the held vector.
- P=G=16, t=0 → lane high for all 16 phases and low in the following idle cycle.
- Loopback with not_equal: encoder lanes a=3, b=3 → not_equal output stays low. With a=3, b=7 → not_equal output follows lane a's spike.
